// File: rtl/decoder_8b10b_if.sv
// Symbol/byte bus between the link receiver and the 8b/10b decoder.
// The master drives received symbols; the slave (decoder) returns decoded bytes and status.
interface decoder_8b10b_if #(
  parameter int CNT_W = 8
);
  logic [9:0]       iData;
  logic             iValid;
  logic [7:0]       oData;
  logic             RXDATAK;
  logic             oValid;
  logic             CodeErr;
  logic             DispErr;
  logic             RD;
  logic             RXSYNC;
  logic [CNT_W-1:0] ErrCount;

  modport master (
    output iData, iValid,
    input  oData, RXDATAK, oValid, CodeErr, DispErr, RD, RXSYNC, ErrCount
  );

  modport slave (
    input  iData, iValid,
    output oData, RXDATAK, oValid, CodeErr, DispErr, RD, RXSYNC, ErrCount
  );
endinterface

// File: rtl/decoder_8b10b.sv
// Receive-side 8b/10b decoder: table decode, running-disparity tracking,
// comma-based sync FSM and a saturating error counter. One cycle latency.
module decoder_8b10b #(
  parameter int SYNC_GOOD = 4,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 8
) (
  input logic            INTERCLK,
  input logic            Reset,
  decoder_8b10b_if.slave bus
);

  localparam int GW = $clog2(SYNC_GOOD + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(SYNC_GOOD - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {LOS, CHECK, SYNC} sync_state_t;

  sync_state_t      state;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             rd_q;
  logic [CNT_W-1:0] err_cnt;

  // Sub-block views in table order: abcdei and fghj, first-transmitted bit as MSB
  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [3:0] sb4_eff;
  logic [2:0] ones6;
  logic [2:0] ones4;

  assign sb6   = {bus.iData[0], bus.iData[1], bus.iData[2], bus.iData[3], bus.iData[4], bus.iData[5]};
  assign sb4   = {bus.iData[6], bus.iData[7], bus.iData[8], bus.iData[9]};
  assign ones6 = 3'($countones(sb6));
  assign ones4 = 3'($countones(sb4));

  logic       ok6, ok4, is_k28, k_x7_6b, a7_6b, is_alt7;
  logic [4:0] edcba;
  logic [2:0] hgf;
  logic       is_k, code_err, disp6, disp4, disp_err, sym_err, is_comma;
  logic       rd_mid, rd_next;
  logic [7:0] byte_val;

  // 6b sub-block lookup; K28 shares EDCBA=28 with D28 and is flagged separately
  always_comb begin
    ok6   = 1'b1;
    edcba = 5'd0;
    case (sb6)
      6'b100111, 6'b011000: edcba = 5'd0;
      6'b011101, 6'b100010: edcba = 5'd1;
      6'b101101, 6'b010010: edcba = 5'd2;
      6'b110001:            edcba = 5'd3;
      6'b110101, 6'b001010: edcba = 5'd4;
      6'b101001:            edcba = 5'd5;
      6'b011001:            edcba = 5'd6;
      6'b111000, 6'b000111: edcba = 5'd7;
      6'b111001, 6'b000110: edcba = 5'd8;
      6'b100101:            edcba = 5'd9;
      6'b010101:            edcba = 5'd10;
      6'b110100:            edcba = 5'd11;
      6'b001101:            edcba = 5'd12;
      6'b101100:            edcba = 5'd13;
      6'b011100:            edcba = 5'd14;
      6'b010111, 6'b101000: edcba = 5'd15;
      6'b011011, 6'b100100: edcba = 5'd16;
      6'b100011:            edcba = 5'd17;
      6'b010011:            edcba = 5'd18;
      6'b110010:            edcba = 5'd19;
      6'b001011:            edcba = 5'd20;
      6'b101010:            edcba = 5'd21;
      6'b011010:            edcba = 5'd22;
      6'b111010, 6'b000101: edcba = 5'd23;
      6'b110011, 6'b001100: edcba = 5'd24;
      6'b100110:            edcba = 5'd25;
      6'b010110:            edcba = 5'd26;
      6'b110110, 6'b001001: edcba = 5'd27;
      6'b001110, 6'b001111, 6'b110000: edcba = 5'd28;
      6'b101110, 6'b010001: edcba = 5'd29;
      6'b011110, 6'b100001: edcba = 5'd30;
      6'b101011, 6'b010100: edcba = 5'd31;
      default:              ok6 = 1'b0;
    endcase
  end

  // K28 in its RD+ form carries the complemented 4b, so flip it back before lookup
  assign is_k28  = (sb6 == 6'b001111) || (sb6 == 6'b110000);
  assign sb4_eff = (sb6 == 6'b110000) ? ~sb4 : sb4;
  assign is_alt7 = (sb4_eff == 4'b0111) || (sb4_eff == 4'b1000);
  assign k_x7_6b = (sb6 == 6'b111010) || (sb6 == 6'b000101) || (sb6 == 6'b110110) ||
                   (sb6 == 6'b001001) || (sb6 == 6'b101110) || (sb6 == 6'b010001) ||
                   (sb6 == 6'b011110) || (sb6 == 6'b100001);
  assign a7_6b   = (sb6 == 6'b110100) || (sb6 == 6'b101100) || (sb6 == 6'b011100) ||
                   (sb6 == 6'b100011) || (sb6 == 6'b010011) || (sb6 == 6'b001011);

  // 4b sub-block lookup including both x.7 encodings
  always_comb begin
    ok4 = 1'b1;
    hgf = 3'd0;
    case (sb4_eff)
      4'b1011, 4'b0100: hgf = 3'd0;
      4'b1001:          hgf = 3'd1;
      4'b0101:          hgf = 3'd2;
      4'b1100, 4'b0011: hgf = 3'd3;
      4'b1101, 4'b0010: hgf = 3'd4;
      4'b1010:          hgf = 3'd5;
      4'b0110:          hgf = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
      default:          ok4 = 1'b0;
    endcase
  end

  // Alternate x.7 is only legal as Kx.7 or as A7 after the run-length-limited data codes
  assign is_k     = ok6 && ok4 && (is_k28 || (k_x7_6b && is_alt7));
  assign code_err = !ok6 || !ok4 || (is_alt7 && !is_k28 && !k_x7_6b && !a7_6b);
  assign byte_val = {hgf, edcba};
  assign is_comma = is_k && ((byte_val == 8'h3C) || (byte_val == 8'hBC) || (byte_val == 8'hFC));

  // Disparity: 6b against current RD, then 4b against the RD left by the 6b block
  always_comb begin
    rd_mid = rd_q;
    disp6  = 1'b0;
    case (ones6)
      3'd4:    begin disp6 = rd_q;  rd_mid = 1'b1; end
      3'd2:    begin disp6 = !rd_q; rd_mid = 1'b0; end
      3'd3:    disp6 = ((sb6 == 6'b111000) && rd_q) || ((sb6 == 6'b000111) && !rd_q);
      default: disp6 = 1'b0;
    endcase
    rd_next = rd_mid;
    disp4   = 1'b0;
    case (ones4)
      3'd3:    begin disp4 = rd_mid;  rd_next = 1'b1; end
      3'd1:    begin disp4 = !rd_mid; rd_next = 1'b0; end
      3'd2:    disp4 = ((sb4 == 4'b1100) && rd_mid) || ((sb4 == 4'b0011) && !rd_mid);
      default: disp4 = 1'b0;
    endcase
  end

  assign disp_err = disp6 || disp4;
  assign sym_err  = code_err || disp_err;

  // Decoded data, flags, running disparity and the saturating error count
  always_ff @(posedge INTERCLK) begin
    if (Reset) begin
      bus.oData   <= 8'h00;
      bus.RXDATAK <= 1'b0;
      bus.oValid  <= 1'b0;
      bus.CodeErr <= 1'b0;
      bus.DispErr <= 1'b0;
      rd_q        <= 1'b0;
      err_cnt     <= '0;
    end else if (bus.iValid) begin
      bus.oValid  <= 1'b1;
      bus.oData   <= code_err ? 8'h00 : byte_val;
      bus.RXDATAK <= is_k && !code_err;
      bus.CodeErr <= code_err;
      bus.DispErr <= disp_err;
      rd_q        <= rd_next;
      if (sym_err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
    end else begin
      bus.oValid  <= 1'b0;
    end
  end

  // Comma-driven link sync FSM; RXSYNC is registered alongside the state
  always_ff @(posedge INTERCLK) begin
    if (Reset) begin
      state      <= LOS;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      bus.RXSYNC <= 1'b0;
    end else if (bus.iValid) begin
      case (state)
        LOS: begin
          if (!sym_err && is_comma) begin
            state    <= CHECK;
            good_cnt <= GW'(1);
          end
        end
        CHECK: begin
          if (sym_err) begin
            state    <= LOS;
            good_cnt <= '0;
          end else if (good_cnt == GOOD_LAST) begin
            state      <= SYNC;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            bus.RXSYNC <= 1'b1;
          end else begin
            good_cnt <= good_cnt + GW'(1);
          end
        end
        SYNC: begin
          if (!sym_err) begin
            bad_cnt <= '0;
          end else if (bad_cnt == BAD_LAST) begin
            state      <= LOS;
            bad_cnt    <= '0;
            bus.RXSYNC <= 1'b0;
          end else begin
            bad_cnt <= bad_cnt + BW'(1);
          end
        end
        default: begin
          state      <= LOS;
          good_cnt   <= '0;
          bad_cnt    <= '0;
          bus.RXSYNC <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RD       = rd_q;
  assign bus.ErrCount = err_cnt;

endmodule

// File: tb/tb_decoder_8b10b.sv
// Scoreboard bench for decoder_8b10b: directed symbols push hand-computed
// expectations, a negedge monitor pops them when oValid is seen.
module tb_decoder_8b10b;

  logic INTERCLK = 1'b0;
  logic Reset;

  decoder_8b10b_if #(.CNT_W(8)) bus ();

  decoder_8b10b #(.SYNC_GOOD(4), .ERR_LIMIT(4), .CNT_W(8)) dut (
    .INTERCLK (INTERCLK),
    .Reset    (Reset),
    .bus      (bus)
  );

  // 10 ns symbol clock
  always #5 INTERCLK = ~INTERCLK;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       cerr;
    logic       derr;
    logic       rd;
    logic       sync;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold_exp;
  exp_t popped;
  logic rst_d;
  int   total = 0;
  int   bad   = 0;
  int   sym_idx = 0;

  function automatic exp_t mk(input logic [7:0] d, input logic k, input logic ce,
                              input logic de, input logic rd, input logic sy,
                              input logic [7:0] cnt);
    exp_t e;
    e.data = d; e.k = k; e.cerr = ce; e.derr = de; e.rd = rd; e.sync = sy; e.cnt = cnt;
    return e;
  endfunction

  task automatic cmpField(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    cmpField({tag, ".oData"},    bus.oData,               e.data);
    cmpField({tag, ".RXDATAK"},  {7'd0, bus.RXDATAK},     {7'd0, e.k});
    cmpField({tag, ".CodeErr"},  {7'd0, bus.CodeErr},     {7'd0, e.cerr});
    cmpField({tag, ".DispErr"},  {7'd0, bus.DispErr},     {7'd0, e.derr});
    cmpField({tag, ".RD"},       {7'd0, bus.RD},          {7'd0, e.rd});
    cmpField({tag, ".RXSYNC"},   {7'd0, bus.RXSYNC},      {7'd0, e.sync});
    cmpField({tag, ".ErrCount"}, bus.ErrCount,            e.cnt);
  endtask

  // Monitor: reset edges expect zeros, valid outputs pop the scoreboard, idle cycles must hold
  initial begin : monitor
    hold_exp = '0;
    forever begin
      @(posedge INTERCLK);
      rst_d = Reset;
      @(negedge INTERCLK);
      if (rst_d === 1'b1) begin
        hold_exp = '0;
        cmpField("rst.oValid", {7'd0, bus.oValid}, 8'd0);
        checkOutput(hold_exp, "rst");
      end else if (bus.oValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_oValid: actual=1 required=0 at %0t", $time);
        end else begin
          popped = exp_q.pop_front();
          checkOutput(popped, $sformatf("sym%0d", sym_idx));
          hold_exp = popped;
          sym_idx++;
        end
      end else begin
        cmpField("idle.oValid", {7'd0, bus.oValid}, 8'd0);
        checkOutput(hold_exp, "hold");
      end
    end
  end

  task automatic applyStimulus(input logic [9:0] d, input exp_t e);
    @(posedge INTERCLK);
    #2;
    bus.iData  = d;
    bus.iValid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic applyIdle(input int n);
    repeat (n) begin
      @(posedge INTERCLK);
      #2;
      bus.iValid = 1'b0;
    end
  endtask

  task automatic applyReset(input logic v, input logic [9:0] d);
    @(posedge INTERCLK);
    #2;
    Reset      = 1'b1;
    bus.iValid = v;
    bus.iData  = d;
    @(posedge INTERCLK);
    #2;
    bus.iValid = 1'b0;
    @(posedge INTERCLK);
    #2;
    Reset = 1'b0;
  endtask

  localparam logic [9:0] K285N = 10'h17C;
  localparam logic [9:0] K285P = 10'h283;
  localparam logic [9:0] D215  = 10'h155;
  localparam logic [9:0] ALL1  = 10'h3FF;
  localparam logic [9:0] ALL0  = 10'h000;
  localparam logic [9:0] D000N = 10'h0B9;
  localparam logic [9:0] D210B = 10'h095;

  initial begin : driver
    Reset      = 1'b1;
    bus.iValid = 1'b0;
    bus.iData  = 10'h000;

    // Reset state with idle input
    applyReset(1'b0, 10'h000);
    applyIdle(2);

    // K28.5 in both disparities
    applyStimulus(K285N, mk(8'hBC, 1, 0, 0, 1, 0, 8'd0));
    applyStimulus(K285P, mk(8'hBC, 1, 0, 0, 0, 0, 8'd0));

    // Comma plus three clean symbols reaches SYNC, then error run drops it
    applyReset(1'b0, 10'h000);
    applyStimulus(K285N, mk(8'hBC, 1, 0, 0, 1, 0, 8'd0));
    applyStimulus(D215,  mk(8'hB5, 0, 0, 0, 1, 0, 8'd0));
    applyStimulus(D215,  mk(8'hB5, 0, 0, 0, 1, 0, 8'd0));
    applyStimulus(D215,  mk(8'hB5, 0, 0, 0, 1, 1, 8'd0));
    applyIdle(2);
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 1, 8'd1));
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 1, 8'd2));
    applyStimulus(D215,  mk(8'hB5, 0, 0, 0, 1, 1, 8'd2));
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 1, 8'd3));
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 1, 8'd4));
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 1, 8'd5));
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 0, 8'd6));
    applyStimulus(D000N, mk(8'h00, 0, 0, 1, 0, 0, 8'd7));

    // Disparity and code violations from RD-
    applyReset(1'b0, 10'h000);
    applyStimulus(K285P, mk(8'hBC, 1, 0, 1, 0, 0, 8'd1));
    applyStimulus(ALL0,  mk(8'h00, 0, 1, 0, 0, 0, 8'd2));
    applyStimulus(D210B, mk(8'h15, 0, 0, 1, 0, 0, 8'd3));
    applyStimulus(D000N, mk(8'h00, 0, 0, 0, 0, 0, 8'd3));

    // Idle holds, then reset overriding a valid symbol mid-stream
    applyReset(1'b0, 10'h000);
    applyStimulus(K285N, mk(8'hBC, 1, 0, 0, 1, 0, 8'd0));
    applyIdle(2);
    applyStimulus(ALL1,  mk(8'h00, 0, 1, 0, 1, 0, 8'd1));
    applyReset(1'b1, K285N);
    applyStimulus(K285P, mk(8'hBC, 1, 0, 1, 0, 0, 8'd1));
    applyStimulus(K285N, mk(8'hBC, 1, 0, 0, 1, 0, 8'd1));
    applyIdle(1);

    // ErrCount saturates at 255
    applyReset(1'b0, 10'h000);
    for (int i = 0; i < 260; i++)
      applyStimulus(ALL1, mk(8'h00, 0, 1, 0, 0, 0, (i + 1 > 255) ? 8'd255 : 8'(i + 1)));
    applyIdle(2);

    // Every issued symbol must have been answered
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge INTERCLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
